// File: rtl/stack_arbiter_if.sv
// Requester-side bus of the stack arbiter: two request channels, the shared
// completion/status returns and the clear request.
interface stack_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int CNTW  = 6
);
  logic             clr;
  logic             req0;
  logic             rw0;
  logic [WIDTH-1:0] wdata0;
  logic             ack0;
  logic             req1;
  logic             rw1;
  logic [WIDTH-1:0] wdata1;
  logic             ack1;
  logic             err;
  logic [WIDTH-1:0] rdata;
  logic [CNTW-1:0]  count;
  logic             full;
  logic             empty;

  // Requester side: drives requests, observes completions and occupancy.
  modport master (
    output clr, req0, rw0, wdata0, req1, rw1, wdata1,
    input  ack0, ack1, err, rdata, count, full, empty
  );

  // Arbiter side.
  modport slave (
    input  clr, req0, rw0, wdata0, req1, rw1, wdata1,
    output ack0, ack1, err, rdata, count, full, empty
  );
endinterface

// File: rtl/stack_arbiter.sv
// Round-robin arbiter and sequencer sharing one flag-less LIFO stack between
// two requesters. Tracks occupancy itself, rejects overflow/underflow with an
// error ack, and clears the stack on every reset exit or on request.
module stack_arbiter #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  stack_arbiter_if.slave   bus,
  output logic             stk_en,
  output logic             stk_rst,
  output logic             stk_rw,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout
);

  typedef enum logic [1:0] {INIT, IDLE, ISSUE, CAPT} state_t;

  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(DEPTH);

  state_t           state;
  state_t           state_next;
  logic [CNTW-1:0]  count;
  logic             rr;
  logic             gnt_id;
  logic             pend_err;
  logic [WIDTH-1:0] rdata;
  logic             ack0;
  logic             ack1;
  logic             err;

  logic             idle_ready;
  logic             any_req;
  logic             grant_sel;
  logic             grant_rw;
  logic [WIDTH-1:0] grant_data;
  logic             grant_err;

  // Arbitration decode: rr names the requester that wins the next tie.
  always_comb begin
    idle_ready = (state == IDLE) && !ack0 && !ack1;
    any_req    = bus.req0 || bus.req1;
    grant_sel  = (bus.req0 && bus.req1) ? rr : bus.req1;
    grant_rw   = grant_sel ? bus.rw1 : bus.rw0;
    grant_data = grant_sel ? bus.wdata1 : bus.wdata0;
    grant_err  = (grant_rw && (count == DEPTH_C)) || (!grant_rw && (count == '0));
  end

  // State register; reset always lands in INIT so the stack gets cleared.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= INIT;
    else      state <= state_next;
  end

  // Next-state logic; a clear request in IDLE takes priority over requests.
  always_comb begin
    state_next = state;
    case (state)
      INIT:  state_next = IDLE;
      IDLE: begin
        if (bus.clr)                   state_next = INIT;
        else if (idle_ready && any_req) state_next = ISSUE;
      end
      ISSUE: state_next = CAPT;
      CAPT:  state_next = IDLE;
      default: state_next = INIT;
    endcase
  end

  // Moore stack strobes: clear in INIT, access in ISSUE unless the op was rejected.
  always_comb begin
    stk_en  = 1'b0;
    stk_rst = 1'b0;
    case (state)
      INIT: begin
        stk_en  = 1'b1;
        stk_rst = 1'b1;
      end
      ISSUE:   stk_en = !pend_err;
      default: ;
    endcase
  end

  // Grant latching, occupancy tracking and the one-cycle ack/err pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count    <= '0;
      rr       <= 1'b0;
      gnt_id   <= 1'b0;
      pend_err <= 1'b0;
      stk_rw   <= 1'b0;
      stk_din  <= '0;
      rdata    <= '0;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      err      <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      err  <= 1'b0;
      case (state)
        INIT: count <= '0;
        IDLE: begin
          if (bus.clr) begin
            count <= '0;
          end else if (idle_ready && any_req) begin
            gnt_id   <= grant_sel;
            stk_rw   <= grant_rw;
            stk_din  <= grant_data;
            pend_err <= grant_err;
            rr       <= !grant_sel;
          end
        end
        ISSUE: begin
          if (!pend_err) count <= stk_rw ? count + 1'b1 : count - 1'b1;
        end
        CAPT: begin
          ack0 <= !gnt_id;
          ack1 <= gnt_id;
          err  <= pend_err;
          if (!stk_rw && !pend_err) rdata <= stk_dout;
        end
        default: ;
      endcase
    end
  end

  assign bus.ack0  = ack0;
  assign bus.ack1  = ack1;
  assign bus.err   = err;
  assign bus.rdata = rdata;
  assign bus.count = count;
  assign bus.full  = (count == DEPTH_C);
  assign bus.empty = (count == '0);

endmodule

// File: doc/stack_arbiter.md
Name: stack_arbiter

Overview:
Two-port arbiter and sequencer in front of the 32x16 LIFO stack. It shares the single stack between requester 0 (call/return unit) and requester 1 (data push/pop unit), using round-robin grant. It issues the stack's en/rw/Din/rst strobes and tracks occupancy, since the stack exposes no full/empty flags. It rejects overflow and underflow with an error ack, and clears the stack after reset or on request.

Parameters:
WIDTH, 16, data width; must match the stack.
DEPTH, 32, stack slot count.
CNTW, 6, occupancy counter width; must hold the value DEPTH.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
clr  input  1  synchronous clear request, sampled in IDLE
req0  input  1  requester 0 request; held until ack0
rw0  input  1  requester 0 op: 1 push, 0 pop; stable while req0
wdata0  input  WIDTH  requester 0 push data; stable while req0
ack0  output  1  one-cycle completion pulse to requester 0
req1, rw1, wdata1  input  1/1/WIDTH  requester 1, same rules as requester 0
ack1  output  1  one-cycle completion pulse to requester 1
err  output  1  qualifies ack0/ack1: op rejected (push when full, pop when empty)
rdata  output  WIDTH  popped data; valid while ack0/ack1 is high for a successful pop
count  output  CNTW  current occupancy, 0..DEPTH
full, empty  output  1  count==DEPTH, count==0
stk_en, stk_rst, stk_rw  output  1  stack enable, stack synchronous clear (active-high), stack rw
stk_din  output  WIDTH  stack write data
stk_dout  input  WIDTH  stack read data

Behaviour:
- FSM states: INIT, IDLE, ISSUE, CAPT. The stack strobes are decoded from registered state (Moore outputs).
- Reset (rst=0, asynchronous):
  - state=INIT; count=0; rr pointer=0; rdata=0; ack0=ack1=err=0; stk_rw=0; stk_din=0.
  - stk_en=stk_rst=1 while in INIT. Clock edges during reset clear the stack; this is harmless.
- INIT: stk_en=1, stk_rst=1 for one cycle, then IDLE. Every exit from reset clears the stack, because the stack has no reset of its own.
- IDLE: stk_en=0. Requests are accepted only when ack0=ack1=0, so the just-acked requester can drop its req.
- IDLE priority order:
  - clr=1: go to INIT, count<=0, no ack.
  - Both requesting: grant the requester other than the last granted. After reset, requester 0 wins the first tie.
  - Single requester: grant it.
- On grant:
  - Latch the id, rw and wdata into stk_rw/stk_din.
  - Set pend_err = (push && count==DEPTH) || (pop && count==0).
  - Update the rr pointer, including on errored grants. Go to ISSUE.
- ISSUE: stk_en = !pend_err; stk_rst=0. On the closing edge: push increments count, pop decrements it; when pend_err=1 count is unchanged. Go to CAPT.
- CAPT: stk_en=0; stk_dout is now valid. On the closing edge:
  - ackN<=1 for the granted requester; err<=pend_err.
  - rdata<=stk_dout for a successful pop; rdata is unchanged otherwise.
  - Go to IDLE.
- Ack pulse: ackN/err are high for exactly one cycle, the first IDLE cycle, then clear.
- Latency: req sampled in IDLE cycle n gives ack high in cycle n+3. Throughput is one op per 4 cycles.
- full/empty/count are combinational from count and track the ISSUE edge.
- count never exceeds DEPTH or underflows. Errored ops do not strobe the stack, so stack contents are untouched.
- Asynchronous reset mid-transaction: the transaction is dropped with no ack, and the INIT sequence re-clears the stack.
- A requester changing rw/wdata before ack is illegal. The arbiter uses only the values latched at grant.

Test Plan:
- Reset release -> one cycle with stk_en=1, stk_rst=1, then IDLE; count=0, empty=1, full=0, all acks 0.
- req0 push 16'hBEEF, then req0 pop -> each ack0 arrives 3 cycles after the req sample; pop gives rdata=16'hBEEF, err=0; count goes 1 then 0.
- req1 pop on empty stack -> ack1 with err=1; stk_en stays 0 throughout; count=0; rdata unchanged.
- 32 pushes of values 0..31 -> full=1, count=32. 33rd push -> err=1, no stk_en. Then 32 pops -> values 31..0 in order, then empty=1.
- req0 and req1 held continuously, both pushing (A=16'h1111, B=16'h2222) -> grants alternate 0,1,0,1 starting with 0, each ack 4 cycles apart. Pops return the LIFO order of the interleaved data.
- Push 3 values, then assert clr in IDLE -> INIT cycle with stk_rst=1, count=0. Assert rst low during an ISSUE cycle -> no ack issued; after release an INIT cycle runs, and a following pop returns err=1.
